// File: rtl/apb_pkg.sv
// apb_pkg: APB phase encoding and default bus widths shared by apb_rr_master
package apb_pkg;
  typedef enum logic [1:0] {IDLE = 2'b00, SETUP = 2'b01, ACCESS = 2'b10} apb_state_t;
  localparam int APB_ADDR_W = 5;
  localparam int APB_DATA_W = 8;
endpackage

// File: rtl/apb_rr_master_arbiter.sv
// rr_arbiter: combinational round-robin pick, first requester at or after ptr_i wins
module rr_arbiter
  import apb_pkg::*;
#(
  parameter int N  = 2,
  parameter int PW = 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [PW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic          grant_valid_o
);
  always_comb begin
    gnt_o = '0;
    for (int k = N - 1; k >= 0; k--)
      if (req_i[PW'((int'(ptr_i) + k) % N)]) gnt_o = N'(1) << ((int'(ptr_i) + k) % N);
  end
  assign grant_valid_o = |req_i;
endmodule

// File: rtl/apb_rr_master.sv
// apb_rr_master: round-robin APB master for NUM_REQ requesters.
// Optional ACCESS timeout abort enabled by defining APB_RR_TIMEOUT_EN.
module apb_rr_master
  import apb_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = APB_ADDR_W,
  parameter int DATA_W  = APB_DATA_W,
  parameter int TIMEOUT = 16
) (
  input  logic                      CLK,
  input  logic                      Rst,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ-1:0]        req_write,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        done,
  output logic [DATA_W-1:0]         rdata,
  output logic                      err,
  output logic                      PSEL,
  output logic                      PENABLE,
  output logic                      PWRITE,
  output logic [ADDR_W-1:0]         PADDR,
  output logic [DATA_W-1:0]         PWDATA,
  input  logic                      PREADY,
  input  logic                      PSLVERR,
  input  logic [DATA_W-1:0]         PRDATA
);
  localparam int PW = $clog2(NUM_REQ);
  apb_state_t state_q, state_d;
  logic [PW-1:0] owner_q, owner_d, ptr_q, ptr_d, gidx;
  logic write_q, write_d, err_q, err_d, psel_q, penable_q;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d, rdata_q, rdata_d;
  logic [NUM_REQ-1:0] done_q, done_d, own_oh, elig, gnt;
  logic gv, fin, abort;
`ifdef APB_RR_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  assign cnt_d = state_q == ACCESS ? cnt_q + CW'(1) : '0;
  assign abort = state_q == ACCESS && !PREADY && cnt_q == CW'(TIMEOUT - 1);
  always_ff @(posedge CLK or posedge Rst)
    if (Rst) cnt_q <= '0;
    else cnt_q <= cnt_d;
`else
  localparam int unused_timeout = TIMEOUT;
  assign abort = 1'b0;
`endif
  assign fin    = state_q == ACCESS && PREADY;
  assign own_oh = NUM_REQ'(1) << owner_q;
  // the finishing owner stays masked on its completion edge and through its done cycle
  assign elig   = req & ~done_q & ~(fin ? own_oh : '0);
  rr_arbiter #(.N(NUM_REQ), .PW(PW)) u_arb (
    .req_i(elig),
    .ptr_i(ptr_q),
    .gnt_o(gnt),
    .grant_valid_o(gv)
  );
  always_comb begin
    gidx    = '0;
    for (int k = 0; k < NUM_REQ; k++) if (gnt[k]) gidx = PW'(k);
    state_d = state_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    write_d = write_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    done_d  = '0;
    rdata_d = '0;
    err_d   = 1'b0;
    if (fin || abort) begin
      done_d  = own_oh;
      rdata_d = (fin && !write_q) ? PRDATA : '0;
      err_d   = abort || PSLVERR;
      ptr_d   = owner_q == PW'(NUM_REQ - 1) ? '0 : owner_q + PW'(1);
      state_d = IDLE;
    end
    if (state_q == SETUP) state_d = ACCESS;
    if ((state_q == IDLE || fin) && gv) begin
      state_d = SETUP;
      owner_d = gidx;
      write_d = req_write[gidx];
      addr_d  = req_addr[gidx*ADDR_W +: ADDR_W];
      wdata_d = req_wdata[gidx*DATA_W +: DATA_W];
    end
  end
  always_ff @(posedge CLK or posedge Rst)
    if (Rst) begin
      state_q   <= IDLE;
      owner_q   <= '0;
      ptr_q     <= '0;
      write_q   <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      done_q    <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
      psel_q    <= 1'b0;
      penable_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      ptr_q     <= ptr_d;
      write_q   <= write_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      done_q    <= done_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
      psel_q    <= state_d != IDLE;
      penable_q <= state_d == ACCESS;
    end
  assign done    = done_q;
  assign rdata   = rdata_q;
  assign err     = err_q;
  assign PSEL    = psel_q;
  assign PENABLE = penable_q;
  assign PWRITE  = write_q;
  assign PADDR   = addr_q;
  assign PWDATA  = wdata_q;
endmodule

// File: tb/tb_apb_rr_master.sv
// tb_apb_rr_master: scoreboard bench with a transfer-level reference model of the round-robin APB master
module tb_apb_rr_master;
  localparam int N = 2, AW = 5, DW = 8, TO = 4;
  logic CLK = 1'b0, Rst = 1'b1;
  logic [N-1:0] req = '0, req_write = '0, done, got;
  logic [N*AW-1:0] req_addr = '0;
  logic [N*DW-1:0] req_wdata = '0;
  logic [DW-1:0] rdata, PWDATA, PRDATA = '0;
  logic [AW-1:0] PADDR;
  logic err, PSEL, PENABLE, PWRITE, PREADY = 1'b0, PSLVERR = 1'b0;
  int checks = 0, errors = 0;
  typedef struct {int who; logic [DW-1:0] rd; logic e;} exp_t;
  exp_t sb[$];
  int m_phase = 0, m_owner = 0, m_ptr = 0, m_cnt = 0;
  logic [N-1:0] m_dmask = '0;
  logic m_w = 1'b0;
  logic [AW-1:0] m_a = '0;
  logic [DW-1:0] m_d = '0;

  always #5 CLK = ~CLK;

  apb_rr_master #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .CLK(CLK), .Rst(Rst), .req(req), .req_write(req_write), .req_addr(req_addr),
    .req_wdata(req_wdata), .done(done), .rdata(rdata), .err(err), .PSEL(PSEL),
    .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
    .PREADY(PREADY), .PSLVERR(PSLVERR), .PRDATA(PRDATA)
  );

  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got %0h want %0h at %0t", nm, a, e, $time);
    end
  endtask

  // reference model: advances one transfer-level step per clock edge
  initial forever begin
    @(posedge CLK);
    #1;
    if (Rst) begin
      m_phase = 0; m_owner = 0; m_ptr = 0; m_cnt = 0; m_dmask = '0;
      sb.delete();
    end else begin : step
      int p, win;
      bit comp, abrt;
      logic [N-1:0] el;
      p = m_phase;
      comp = p == 2 && PREADY;
      abrt = 1'b0;
`ifdef APB_RR_TIMEOUT_EN
      if (p == 2 && !PREADY) begin
        m_cnt++;
        abrt = m_cnt == TO;
      end
`endif
      el = req & ~m_dmask;
      if (comp) el[m_owner] = 1'b0;
      win = -1;
      for (int k = 0; k < N; k++) begin
        int c;
        c = (m_ptr + k) % N;
        if (el[c]) begin
          win = c;
          break;
        end
      end
      m_dmask = '0;
      if (comp || abrt) begin
        sb.push_back('{who: m_owner, rd: (comp && !m_w) ? PRDATA : '0, e: abrt ? 1'b1 : PSLVERR});
        m_ptr = (m_owner + 1) % N;
        m_dmask[m_owner] = 1'b1;
      end
      if (p == 1) m_phase = 2;
      else if ((p == 0 || comp) && win >= 0) begin
        m_phase = 1;
        m_owner = win;
        m_w = req_write[win];
        m_a = req_addr[win*AW +: AW];
        m_d = req_wdata[win*DW +: DW];
        m_cnt = 0;
      end else if (comp || abrt) m_phase = 0;
    end
    chk("psel", PSEL, m_phase != 0);
    chk("penable", PENABLE, m_phase == 2);
    if (m_phase != 0) begin
      chk("paddr", PADDR, m_a);
      chk("pwrite", PWRITE, m_w);
      if (m_w) chk("pwdata", PWDATA, m_d);
    end
  end

  // completion monitor: every predicted completion must appear exactly one cycle later
  initial forever begin
    @(negedge CLK);
    if (|done) begin
      if (sb.size() == 0) chk("spurious_done", done, 0);
      else begin : pop
        exp_t x;
        x = sb.pop_front();
        chk("done_who", done, N'(1) << x.who);
        chk("rdata", rdata, x.rd);
        chk("err", err, x.e);
      end
    end else if (sb.size() != 0) begin
      chk("missing_done", done, N'(1) << sb[0].who);
      void'(sb.pop_front());
    end
  end

  task automatic tick();
    @(negedge CLK);
    got = done;
    for (int i = 0; i < N; i++) if (req[i] && done[i]) req[i] = 1'b0;
  endtask

  task automatic issue(input int i, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_write[i] = w;
    req_addr[i*AW +: AW] = a;
    req_wdata[i*DW +: DW] = d;
    req[i] = 1'b1;
  endtask

  task automatic single(input int i, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input int waits, input logic [DW-1:0] prd, input logic se,
                        input int exp_lat, input logic [DW-1:0] exp_rd, input logic exp_err);
    int lat;
    PRDATA = prd;
    PSLVERR = se;
    PREADY = 1'b0;
    issue(i, w, a, d);
    lat = -1;
    for (int t = 1; t <= 30 && lat < 0; t++) begin
      tick();
      if (got[i]) begin
        lat = t;
        chk("dir_rdata", rdata, exp_rd);
        chk("dir_err", err, exp_err);
      end
      PREADY = t >= 2 + waits;
    end
    chk("latency", lat, exp_lat);
    tick();
  endtask

  initial begin
    int n;
    repeat (3) tick();
    chk("rst_psel", PSEL, 0);
    chk("rst_penable", PENABLE, 0);
    chk("rst_done", done, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_err", err, 0);
    chk("rst_paddr", PADDR, 0);
    chk("rst_pwdata", PWDATA, 0);
    Rst = 1'b0;
    tick();
    single(0, 1'b1, 5'h03, 8'hA5, 0, 8'h5A, 1'b0, 3, 8'h00, 1'b0);
    single(1, 1'b0, 5'h03, 8'h00, 2, 8'hA5, 1'b0, 5, 8'hA5, 1'b0);
    single(0, 1'b1, 5'h07, 8'h3C, 0, 8'h00, 1'b1, 3, 8'h00, 1'b1);
    single(1, 1'b0, 5'h09, 8'h00, 1, 8'h66, 1'b0, 4, 8'h66, 1'b0);
`ifdef APB_RR_TIMEOUT_EN
    single(0, 1'b0, 5'h04, 8'h00, 100, 8'h77, 1'b0, 2 + TO, 8'h00, 1'b1);
`endif
    PREADY = 1'b1;
    PSLVERR = 1'b0;
    issue(0, 1'b1, 5'h01, 8'h10);
    issue(1, 1'b1, 5'h02, 8'h20);
    n = 0;
    for (int t = 0; t < 40; t++) begin
      tick();
      if (t >= 10 && t < 30 && |got) n++;
      PRDATA = DW'($urandom);
      for (int i = 0; i < N; i++)
        if (!req[i] && !got[i]) issue(i, 1'($urandom), AW'($urandom), DW'($urandom));
    end
    chk("fair_done_rate", n, 10);
    repeat (8) tick();
    for (int t = 0; t < 400; t++) begin
      tick();
      PREADY = $urandom_range(0, 2) != 0;
      PRDATA = DW'($urandom);
      PSLVERR = $urandom_range(0, 7) == 0;
      for (int i = 0; i < N; i++)
        if (!req[i] && !got[i] && $urandom_range(0, 3) == 0)
          issue(i, 1'($urandom), AW'($urandom), DW'($urandom));
    end
    PREADY = 1'b1;
    PSLVERR = 1'b0;
    repeat (12) tick();
    PREADY = 1'b0;
    issue(0, 1'b0, 5'h05, 8'h00);
    for (int t = 0; t < 10 && !(PSEL && PENABLE); t++) tick();
    chk("reach_access", PSEL && PENABLE, 1);
    #2 Rst = 1'b1;
    req = '0;
    #1;
    chk("midrst_psel", PSEL, 0);
    chk("midrst_penable", PENABLE, 0);
    chk("midrst_done", done, 0);
    tick();
    Rst = 1'b0;
    for (int t = 0; t < 3; t++) begin
      tick();
      chk("postrst_done", got, 0);
    end
    single(1, 1'b1, 5'h02, 8'h11, 0, 8'h00, 1'b0, 3, 8'h00, 1'b0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
endmodule
